mem_responder: RTL and testbench

- Synthesizable memory-side responder for the multicycle RV32I datapath's mem_read/mem_write/mem_resp handshake.
- Stores 2^ADDR_WIDTH 32-bit words and services one word access at a time.
- Returns a single-cycle mem_resp after a fixed, parameterized latency and honours byte enables on writes.
- Used as the instruction/data memory behind the CPU control FSM, both in simulation and in FPGA builds.

---
 rtl/mem_responder_if.sv | 36 +++
 rtl/mem_responder.sv | 145 ++++++++++++++
 tb/tb_mem_responder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU control FSM and the memory responder.
interface mem_responder_if;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;
    logic        busy;
    logic        err;

    modport master (
        output mem_address,
        output mem_read,
        output mem_write,
        output mem_byte_enable,
        output mem_wdata,
        input  mem_rdata,
        input  mem_resp,
        input  busy,
        input  err
    );

    modport slave (
        input  mem_address,
        input  mem_read,
        input  mem_write,
        input  mem_byte_enable,
        input  mem_wdata,
        output mem_rdata,
        output mem_resp,
        output busy,
        output err
    );
endinterface

// File: rtl/mem_responder.sv
// Word-organised memory with fixed-latency single-cycle completion pulse,
// byte-lane writes, request abort and a sticky protocol/range error flag.
module mem_responder #(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 3
) (
    input logic             clk,
    input logic             rst,
    mem_responder_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT =
        (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;

    state_t state;
    state_t state_next;

    logic                  op_write;
    logic [ADDR_WIDTH-1:0] idx_q;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q;
    logic                  oor_q;
    logic [3:0]            cnt;
    logic [31:0]           rdata_q;
    logic                  err_q;

    logic [31:0] mem [2**ADDR_WIDTH];

    logic                  req_one;
    logic                  req_both;
    logic                  accept;
    logic                  op_req;
    logic [ADDR_WIDTH-1:0] idx_in;
    logic                  oor_in;
    logic                  enter_resp;
    logic                  rd_write;
    logic [ADDR_WIDTH-1:0] rd_idx;
    logic                  rd_oor;
    logic                  commit;
    logic [1:0]            unused_addr_bits;

    assign unused_addr_bits = bus.mem_address[1:0];

    assign req_one  = bus.mem_read ^ bus.mem_write;
    assign req_both = bus.mem_read & bus.mem_write;
    assign accept   = (state == IDLE) && req_one;
    assign op_req   = op_write ? bus.mem_write : bus.mem_read;

    assign idx_in = bus.mem_address[ADDR_WIDTH+1:2];
    assign oor_in = |(bus.mem_address >> (ADDR_WIDTH + 2));

    // With LATENCY = 1 RESP is entered straight from IDLE, so the
    // read path must look at the live bus instead of the latches.
    assign rd_write = (state == IDLE) ? bus.mem_write : op_write;
    assign rd_idx   = (state == IDLE) ? idx_in : idx_q;
    assign rd_oor   = (state == IDLE) ? oor_in : oor_q;

    assign enter_resp = (state_next == RESP) && (state != RESP);
    assign commit     = !rst && (state == RESP) && op_write && !oor_q;

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (!op_req) begin
                    state_next = IDLE;
                end else if (cnt == 4'd0) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            op_write <= 1'b0;
            idx_q    <= '0;
            be_q     <= 4'd0;
            wdata_q  <= 32'd0;
            oor_q    <= 1'b0;
            cnt      <= 4'd0;
            rdata_q  <= 32'd0;
            err_q    <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_write <= bus.mem_write;
                idx_q    <= idx_in;
                be_q     <= bus.mem_byte_enable;
                wdata_q  <= bus.mem_wdata;
                oor_q    <= oor_in;
                cnt      <= CNT_INIT;
            end else if (state == WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == IDLE && req_both) begin
                err_q <= 1'b1;
            end
            // Range error is flagged only once the access really completes,
            // so an aborted out-of-range request leaves err untouched.
            if (enter_resp) begin
                if (rd_oor) begin
                    err_q <= 1'b1;
                end
                if (!rd_write) begin
                    rdata_q <= rd_oor ? 32'd0 : mem[rd_idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be_q[b]) begin
                    mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
    end

    assign bus.mem_rdata = rdata_q;
    assign bus.mem_resp  = (state == RESP);
    assign bus.busy      = (state != IDLE);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: transaction table plus hand-written
// sequences for abort, reset, back-to-back and error cases.
module tb_mem_responder;

    localparam int LAT = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    mem_responder_if bus ();

    mem_responder #(
        .ADDR_WIDTH(10),
        .LATENCY(LAT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.mem_read        = 1'b0;
        bus.mem_write       = 1'b0;
        bus.mem_address     = 32'd0;
        bus.mem_byte_enable = 4'd0;
        bus.mem_wdata       = 32'd0;
    endtask

    task automatic drive(input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [3:0] be,
                         input logic [31:0] wd);
        bus.mem_read        = rd;
        bus.mem_write       = wr;
        bus.mem_address     = addr;
        bus.mem_byte_enable = be;
        bus.mem_wdata       = wd;
    endtask

    // Full transaction: request in cycle T, resp expected only at T+LAT.
    task automatic do_txn(input string tag, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [3:0] be,
                          input logic [31:0] wd, input logic [31:0] exp_rd,
                          input logic exp_err);
        drive(rd, wr, addr, be, wd);
        for (int i = 1; i <= LAT; i++) begin
            step();
            chk({tag, " resp"}, 32'(bus.mem_resp), 32'(i == LAT));
            chk({tag, " busy"}, 32'(bus.busy), 32'd1);
        end
        chk({tag, " rdata"}, bus.mem_rdata, exp_rd);
        chk({tag, " err"}, 32'(bus.err), 32'(exp_err));
        step();
        idle_bus();
        chk({tag, " busy after"}, 32'(bus.busy), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_bus();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 1'b1, 32'h40,  4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 1'b0, 32'h40,  4'h0, 32'h0,        32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 32'h42,  4'h4, 32'h00AA0000, 32'hDEADBEEF, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 32'h40,  4'hF, 32'h0,        32'hDEAABEEF, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 32'h80,  4'hF, 32'h12345678, 32'hDEAABEEF, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 32'h80,  4'h0, 32'h0,        32'h12345678, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 32'h80,  4'h0, 32'hFFFFFFFF, 32'h12345678, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 32'h81,  4'h0, 32'h0,        32'h12345678, 1'b0};
        vecs[8]  = '{1'b0, 1'b1, 32'h104, 4'hF, 32'h11111111, 32'h12345678, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 32'h107, 4'h9, 32'hA2000033, 32'h12345678, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 32'h104, 4'h0, 32'h0,        32'hA2111133, 1'b0};

        // Reset state
        do_reset();
        for (int i = 0; i < 3; i++) begin
            chk("rst resp", 32'(bus.mem_resp), 32'd0);
            chk("rst busy", 32'(bus.busy), 32'd0);
            chk("rst err", 32'(bus.err), 32'd0);
            chk("rst rdata", bus.mem_rdata, 32'd0);
            step();
        end

        for (int i = 0; i < 11; i++) begin
            do_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].wr,
                   vecs[i].addr, vecs[i].be, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_err);
        end

        // Abort: write dropped after one WAIT cycle
        drive(1'b0, 1'b1, 32'h80, 4'hF, 32'hFFFFFFFF);
        step();
        chk("abort busy wait", 32'(bus.busy), 32'd1);
        idle_bus();
        for (int i = 0; i < LAT + 1; i++) begin
            step();
            chk("abort resp", 32'(bus.mem_resp), 32'd0);
            chk("abort busy", 32'(bus.busy), 32'd0);
        end
        chk("abort err", 32'(bus.err), 32'd0);
        do_txn("abort rd", 1'b1, 1'b0, 32'h80, 4'h0, 32'h0,
               32'h12345678, 1'b0);

        // Reset during WAIT with the write still requested
        drive(1'b0, 1'b1, 32'h80, 4'hF, 32'hFFFFFFFF);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_bus();
        chk("rstw busy", 32'(bus.busy), 32'd0);
        chk("rstw resp", 32'(bus.mem_resp), 32'd0);
        chk("rstw rdata", bus.mem_rdata, 32'd0);
        for (int i = 0; i < LAT; i++) begin
            step();
            chk("rstw resp idle", 32'(bus.mem_resp), 32'd0);
        end
        do_txn("rstw rd", 1'b1, 1'b0, 32'h80, 4'h0, 32'h0,
               32'h12345678, 1'b0);

        // Reset in the RESP cycle must suppress the write commit
        drive(1'b0, 1'b1, 32'h80, 4'hF, 32'hAAAAAAAA);
        for (int i = 1; i <= LAT; i++) begin
            step();
        end
        chk("rstr resp", 32'(bus.mem_resp), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_bus();
        chk("rstr resp after", 32'(bus.mem_resp), 32'd0);
        chk("rstr busy after", 32'(bus.busy), 32'd0);
        step();
        do_txn("rstr rd", 1'b1, 1'b0, 32'h80, 4'h0, 32'h0,
               32'h12345678, 1'b0);

        // Inputs changed after acceptance are ignored
        drive(1'b0, 1'b1, 32'h100, 4'hF, 32'h5555AAAA);
        step();
        drive(1'b0, 1'b1, 32'h104, 4'h0, 32'h0);
        for (int i = 2; i <= LAT; i++) begin
            step();
        end
        chk("latch resp", 32'(bus.mem_resp), 32'd1);
        step();
        idle_bus();
        do_txn("latch rd100", 1'b1, 1'b0, 32'h100, 4'h0, 32'h0,
               32'h5555AAAA, 1'b0);
        do_txn("latch rd104", 1'b1, 1'b0, 32'h104, 4'h0, 32'h0,
               32'hA2111133, 1'b0);

        // Back-to-back: read held high across two completions
        drive(1'b1, 1'b0, 32'h40, 4'h0, 32'h0);
        for (int i = 1; i <= 2 * LAT + 1; i++) begin
            step();
            chk($sformatf("b2b resp c%0d", i), 32'(bus.mem_resp),
                32'(i == LAT || i == 2 * LAT + 1));
            chk($sformatf("b2b busy c%0d", i), 32'(bus.busy),
                32'(i != LAT + 1));
            if (i == LAT || i == 2 * LAT + 1) begin
                chk("b2b rdata", bus.mem_rdata, 32'hDEAABEEF);
            end
        end
        step();
        idle_bus();
        chk("b2b idle", 32'(bus.busy), 32'd0);
        step();
        chk("b2b no repeat", 32'(bus.busy), 32'd0);

        // Read and write together: error, nothing accepted
        drive(1'b1, 1'b1, 32'h40, 4'hF, 32'h0);
        step();
        idle_bus();
        chk("both err", 32'(bus.err), 32'd1);
        chk("both busy", 32'(bus.busy), 32'd0);
        for (int i = 0; i < LAT + 1; i++) begin
            chk("both resp", 32'(bus.mem_resp), 32'd0);
            step();
        end
        chk("both err sticky", 32'(bus.err), 32'd1);

        // Out-of-range read after reset
        do_reset();
        chk("oor err cleared", 32'(bus.err), 32'd0);
        drive(1'b1, 1'b0, 32'h1000, 4'h0, 32'h0);
        for (int i = 1; i <= LAT; i++) begin
            step();
            chk("oor resp", 32'(bus.mem_resp), 32'(i == LAT));
            chk("oor err", 32'(bus.err), 32'(i == LAT));
        end
        chk("oor rdata", bus.mem_rdata, 32'd0);
        step();
        idle_bus();

        // Out-of-range write aliasing word 0x80 must be dropped
        do_reset();
        do_txn("oor wr", 1'b0, 1'b1, 32'h1080, 4'hF, 32'h99999999,
               32'h0, 1'b1);
        do_txn("oor wr chk", 1'b1, 1'b0, 32'h80, 4'h0, 32'h0,
               32'h12345678, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
